// File: rtl/auto_jogador_busca.sv
// Automatic player for the password game.
// Binary-searches password A (4 bits) and then password B (3 bits) by driving
// guesses into the hint generator and decoding its HEX6 greater/less code.
// Every output is a flop. The hint is registered before it is decoded, so
// there is no combinational path from hex_maior_menor to any output.
module auto_jogador_busca #(
    parameter int PASSO_CICLOS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iniciar,
    input  logic [6:0] hex_maior_menor,
    output logic [3:0] tentativa_a,
    output logic [2:0] tentativa_b,
    output logic       fase_b_ativa,
    output logic       ocupado,
    output logic       concluido,
    output logic       erro,
    output logic [3:0] num_tentativas
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        APLICA    = 3'd1,
        ESPERA    = 3'd2,
        AVALIA    = 3'd3,
        CONCLUIDO = 3'd4,
        ERRO      = 3'd5
    } estado_t;

    localparam logic [3:0] ESPERA_INI = 4'(PASSO_CICLOS - 1);

    // Segment codes produced by the hint generator (active-low segments).
    localparam logic [6:0] HEX_MAIOR = 7'b1001111;
    localparam logic [6:0] HEX_MENOR = 7'b1111001;
    localparam logic [6:0] HEX_IGUAL = 7'b1111111;

    estado_t    estado, estado_prox;
    logic [6:0] hint_q;
    logic [3:0] lo, hi, cnt;
    logic [3:0] lo_d, hi_d, cnt_d;
    logic [3:0] tent_a_d, num_d;
    logic [2:0] tent_b_d;
    logic       fase_d, ocupado_d, concluido_d, erro_d;
    logic [4:0] soma;
    logic [3:0] meio;
    logic       eh_maior, eh_menor, eh_igual, pode_iniciar;

    // The 5-bit sum keeps lo+hi from overflowing before the halving.
    assign soma     = {1'b0, lo} + {1'b0, hi};
    assign meio     = soma[4:1];
    assign eh_maior = (hint_q == HEX_MAIOR);
    assign eh_menor = (hint_q == HEX_MENOR);
    assign eh_igual = (hint_q == HEX_IGUAL);

    // A start pulse is only honoured while no search is in progress.
    assign pode_iniciar = iniciar &&
                          ((estado == OCIOSO) || (estado == CONCLUIDO) || (estado == ERRO));

    // State, search registers, registered hint and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            hint_q         <= '0;
            lo             <= '0;
            hi             <= '0;
            cnt            <= '0;
            tentativa_a    <= '0;
            tentativa_b    <= '0;
            fase_b_ativa   <= 1'b0;
            ocupado        <= 1'b0;
            concluido      <= 1'b0;
            erro           <= 1'b0;
            num_tentativas <= '0;
        end else begin
            estado         <= estado_prox;
            hint_q         <= hex_maior_menor;
            lo             <= lo_d;
            hi             <= hi_d;
            cnt            <= cnt_d;
            tentativa_a    <= tent_a_d;
            tentativa_b    <= tent_b_d;
            fase_b_ativa   <= fase_d;
            ocupado        <= ocupado_d;
            concluido      <= concluido_d;
            erro           <= erro_d;
            num_tentativas <= num_d;
        end
    end

    // Next-state decision for the search sequencer.
    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO, CONCLUIDO, ERRO: begin
                if (pode_iniciar) estado_prox = APLICA;
            end
            APLICA: estado_prox = ESPERA;
            ESPERA: begin
                if (cnt == 4'd0) estado_prox = AVALIA;
            end
            AVALIA: begin
                if (eh_igual)      estado_prox = fase_b_ativa ? CONCLUIDO : APLICA;
                else if (eh_maior) estado_prox = (meio == lo) ? ERRO : APLICA;
                else if (eh_menor) estado_prox = (meio == hi) ? ERRO : APLICA;
                else               estado_prox = ERRO;
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Next values of the search registers and outputs; everything holds by default.
    always_comb begin
        lo_d        = lo;
        hi_d        = hi;
        cnt_d       = cnt;
        tent_a_d    = tentativa_a;
        tent_b_d    = tentativa_b;
        fase_d      = fase_b_ativa;
        ocupado_d   = ocupado;
        concluido_d = concluido;
        erro_d      = erro;
        num_d       = num_tentativas;
        case (estado)
            OCIOSO, CONCLUIDO, ERRO: begin
                if (pode_iniciar) begin
                    lo_d        = 4'd0;
                    hi_d        = 4'd15;
                    tent_a_d    = 4'd0;
                    tent_b_d    = 3'd0;
                    fase_d      = 1'b0;
                    ocupado_d   = 1'b1;
                    concluido_d = 1'b0;
                    erro_d      = 1'b0;
                    num_d       = 4'd0;
                end
            end
            APLICA: begin
                if (fase_b_ativa) tent_b_d = meio[2:0];
                else              tent_a_d = meio;
                num_d = num_tentativas + 4'd1;
                cnt_d = ESPERA_INI;
            end
            ESPERA: begin
                if (cnt != 4'd0) cnt_d = cnt - 4'd1;
            end
            AVALIA: begin
                if (eh_igual) begin
                    if (fase_b_ativa) begin
                        concluido_d = 1'b1;
                        ocupado_d   = 1'b0;
                    end else begin
                        // A found: tentativa_a keeps the answer, B range is 0..7.
                        fase_d = 1'b1;
                        lo_d   = 4'd0;
                        hi_d   = 4'd7;
                    end
                end else if (eh_maior && (meio != lo)) begin
                    hi_d = meio - 4'd1;
                end else if (eh_menor && (meio != hi)) begin
                    lo_d = meio + 4'd1;
                end else begin
                    // Invalid code, or a hint that pushes the range past its end.
                    erro_d    = 1'b1;
                    ocupado_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_auto_jogador_busca.sv
// Bench for auto_jogador_busca: two instances (PASSO_CICLOS=4 and 1), each
// closed through a behavioural hint generator. Expected guesses are queued
// when a search is started and popped whenever num_tentativas steps.
module tb_auto_jogador_busca;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected guesses, encoded as {phase, guess[3:0]}.
    logic [4:0] exp_q0[$];
    logic [4:0] exp_q1[$];
    int prev_num[2];
    int last_cyc[2];

    // Instance 0: PASSO_CICLOS = 4
    logic       ini0;
    logic [6:0] hex0;
    logic [3:0] ta0, num0, sa0;
    logic [2:0] tb0, sb0;
    logic       fase0, ocup0, conc0, erro0;
    int         mode0;
    logic [14:0] o0;

    // Instance 1: PASSO_CICLOS = 1
    logic       ini1;
    logic [6:0] hex1;
    logic [3:0] ta1, num1, sa1;
    logic [2:0] tb1, sb1;
    logic       fase1, ocup1, conc1, erro1;
    int         mode1;
    logic [14:0] o1;

    assign o0 = {ta0, tb0, fase0, ocup0, conc0, erro0, num0};
    assign o1 = {ta1, tb1, fase1, ocup1, conc1, erro1, num1};

    // mode 0: honest generator, 1: always "greater", 2: invalid code
    function automatic logic [6:0] hint_model(input logic fase, input logic [3:0] ta,
                                              input logic [2:0] tbg, input logic [3:0] sa,
                                              input logic [2:0] sb, input int mode);
        logic [3:0] g, s;
        if (mode == 1) return 7'b1001111;
        if (mode == 2) return 7'b0000000;
        g = fase ? {1'b0, tbg} : ta;
        s = fase ? {1'b0, sb} : sa;
        if (g > s) return 7'b1001111;
        if (g < s) return 7'b1111001;
        return 7'b1111111;
    endfunction

    assign hex0 = hint_model(fase0, ta0, tb0, sa0, sb0, mode0);
    assign hex1 = hint_model(fase1, ta1, tb1, sa1, sb1, mode1);

    auto_jogador_busca #(.PASSO_CICLOS(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .iniciar(ini0), .hex_maior_menor(hex0),
        .tentativa_a(ta0), .tentativa_b(tb0), .fase_b_ativa(fase0),
        .ocupado(ocup0), .concluido(conc0), .erro(erro0), .num_tentativas(num0)
    );

    auto_jogador_busca #(.PASSO_CICLOS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .iniciar(ini1), .hex_maior_menor(hex1),
        .tentativa_a(ta1), .tentativa_b(tb1), .fase_b_ativa(fase1),
        .ocupado(ocup1), .concluido(conc1), .erro(erro1), .num_tentativas(num1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every step of num_tentativas is one new guess.
    task automatic watch(input int d, input logic [3:0] num, input logic fase,
                         input logic [3:0] ta, input logic [2:0] tbg);
        logic [4:0] obs, e;
        int sz, hold;
        hold = (d == 0) ? 6 : 3;
        if (int'(num) != prev_num[d]) begin
            if (num != 4'd0) begin
                obs = {fase, fase ? {1'b0, tbg} : ta};
                chk("num_step", 16'(num), 16'(prev_num[d] + 1));
                if (prev_num[d] != 0) chk("guess_hold", 16'(cyc - last_cyc[d]), 16'(hold));
                if (!fase) chk("tb_zero_in_a", 16'(tbg), 16'd0);
                sz = (d == 0) ? exp_q0.size() : exp_q1.size();
                chk("guess_expected", 16'(sz != 0), 16'd1);
                if (sz != 0) begin
                    e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    chk("guess", 16'(obs), 16'(e));
                end
            end
            prev_num[d] = int'(num);
            last_cyc[d] = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        watch(0, num0, fase0, ta0, tb0);
        watch(1, num1, fase1, ta1, tb1);
    endtask

    task automatic pulse(input int d);
        if (d == 0) ini0 = 1'b1; else ini1 = 1'b1;
        tick();
        ini0 = 1'b0;
        ini1 = 1'b0;
    endtask

    task automatic wait_done(input int d);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            done = (d == 0) ? (conc0 | erro0) : (conc1 | erro1);
            if (done) break;
            tick();
        end
        chk("finished_in_time", 16'(done), 16'd1);
    endtask

    task automatic push0(input logic fase, input logic [3:0] g);
        exp_q0.push_back({fase, g});
    endtask

    task automatic push1(input logic fase, input logic [3:0] g);
        exp_q1.push_back({fase, g});
    endtask

    initial begin
        rst_n = 1'b0;
        ini0 = 1'b0; ini1 = 1'b0;
        sa0 = 4'd0; sb0 = 3'd0; mode0 = 0;
        sa1 = 4'd0; sb1 = 3'd0; mode1 = 0;
        prev_num[0] = 0; prev_num[1] = 0;
        last_cyc[0] = 0; last_cyc[1] = 0;

        // Reset state
        repeat (3) tick();
        chk("reset_out0", 16'(o0), 16'd0);
        chk("reset_out1", 16'(o1), 16'd0);
        rst_n = 1'b1;
        repeat (5) tick();
        chk("idle_out0", 16'(o0), 16'd0);

        // Nominal search: A=9, B=0
        sa0 = 4'd9; sb0 = 3'd0;
        push0(0, 7); push0(0, 11); push0(0, 9);
        push0(1, 3); push0(1, 1); push0(1, 0);
        pulse(0);
        wait_done(0);
        tick();
        chk("s1_out", 16'(o0), 16'({4'd9, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6}));
        chk("s1_queue_empty", 16'(exp_q0.size()), 16'd0);

        // Worst case A=15, B=7, with a start pulse in mid-search that must be ignored
        sa0 = 4'd15; sb0 = 3'd7;
        push0(0, 7); push0(0, 11); push0(0, 13); push0(0, 14); push0(0, 15);
        push0(1, 3); push0(1, 5); push0(1, 6); push0(1, 7);
        pulse(0);
        chk("s2_conc_cleared", 16'(conc0), 16'd0);
        repeat (10) tick();
        pulse(0);
        wait_done(0);
        chk("s2_out", 16'(o0), 16'({4'd15, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9}));
        chk("s2_queue_empty", 16'(exp_q0.size()), 16'd0);

        // Inconsistent generator: always "greater"
        mode0 = 1;
        push0(0, 7); push0(0, 3); push0(0, 1); push0(0, 0);
        pulse(0);
        wait_done(0);
        repeat (3) tick();
        chk("s3_erro", 16'({erro0, conc0, ocup0}), 16'({1'b1, 1'b0, 1'b0}));
        chk("s3_num", 16'(num0), 16'd4);
        chk("s3_queue_empty", 16'(exp_q0.size()), 16'd0);

        // Invalid code on the first evaluation, then a clean restart (A=5, B=2)
        mode0 = 2;
        push0(0, 7);
        pulse(0);
        wait_done(0);
        chk("s4_erro", 16'({erro0, ocup0, num0}), 16'({1'b1, 1'b0, 4'd1}));
        mode0 = 0; sa0 = 4'd5; sb0 = 3'd2;
        push0(0, 7); push0(0, 3); push0(0, 5);
        push0(1, 3); push0(1, 1); push0(1, 2);
        pulse(0);
        chk("s4_erro_cleared", 16'({erro0, ocup0}), 16'({1'b0, 1'b1}));
        wait_done(0);
        chk("s4_out", 16'(o0), 16'({4'd5, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6}));
        chk("s4_queue_empty", 16'(exp_q0.size()), 16'd0);

        // Asynchronous reset during phase-B wait
        sa0 = 4'd9; sb0 = 3'd0;
        push0(0, 7); push0(0, 11); push0(0, 9); push0(1, 3);
        pulse(0);
        begin
            logic reached;
            reached = 1'b0;
            for (int i = 0; i < 200; i++) begin
                if (fase0 && (num0 == 4'd4)) begin
                    reached = 1'b1;
                    break;
                end
                tick();
            end
            chk("s5_reached_b", 16'(reached), 16'd1);
        end
        tick();
        #2 rst_n = 1'b0;
        #1 chk("s5_async_reset", 16'(o0), 16'd0);
        chk("s5_queue_empty", 16'(exp_q0.size()), 16'd0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("s5_idle_after_reset", 16'(o0), 16'd0);

        // Shortest wait on instance 1: A=0, B=5
        sa1 = 4'd0; sb1 = 3'd5;
        push1(0, 7); push1(0, 3); push1(0, 1); push1(0, 0);
        push1(1, 3); push1(1, 5);
        pulse(1);
        wait_done(1);
        chk("s6_out", 16'(o1), 16'({4'd0, 3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 4'd6}));
        chk("s6_queue_empty", 16'(exp_q1.size()), 16'd0);
        chk("s6_other_idle", 16'(o0), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
